key_entry_sequencer: RTL

//  Sequences raw keypad strobes into the lock decider's code RAM; sits between the keypad scanner/debouncer and the decider.
//  - Digits are written to RAM addresses 1..DIGITS; the terminator ('#' or '*') is written to address 0.
//  - After the terminator write, one Valid_1 pulse is issued.
//  - Malformed entries are scrubbed to 0 so the decider never sees a stale code.

---
 rtl/lock_pkg.sv | 34 +++
 rtl/key_entry_sequencer_if.sv | 26 ++
 rtl/key_entry_sequencer_entry_timer.sv | 37 +++
 rtl/key_entry_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared key codes, sequencer state encoding and key classification helper.
package lock_pkg;

   // Keypad codes delivered by the scanner/debouncer
   localparam logic [3:0] KEY_0    = 4'b0000;
   localparam logic [3:0] KEY_1    = 4'b0001;
   localparam logic [3:0] KEY_2    = 4'b0010;
   localparam logic [3:0] KEY_3    = 4'b0011;
   localparam logic [3:0] KEY_4    = 4'b0100;
   localparam logic [3:0] KEY_5    = 4'b0101;
   localparam logic [3:0] KEY_6    = 4'b0110;
   localparam logic [3:0] KEY_7    = 4'b0111;
   localparam logic [3:0] KEY_8    = 4'b1000;
   localparam logic [3:0] KEY_9    = 4'b1001;
   localparam logic [3:0] KEY_STAR = 4'b1010;
   localparam logic [3:0] KEY_HASH = 4'b1011;

   localparam int unsigned KEY_W = 4;

   // Entry sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DIGIT = 3'd1,
      ST_TERM  = 3'd2,
      ST_VALID = 3'd3,
      ST_FLUSH = 3'd4
   } state_e;

   // True for the numeric keys 0..9
   function automatic logic is_digit(input logic [3:0] code);
      return (code <= KEY_9);
   endfunction

endpackage

// File: rtl/key_entry_sequencer_if.sv
// Keypad-side strobe inputs and decider-side RAM/valid outputs of the sequencer.
interface key_entry_sequencer_if #(
   parameter int unsigned ADDR_W = 4
);
   logic [3:0]        key_code;
   logic              key_stb;
   logic [3:0]        Code_1;
   logic              write_en;
   logic [ADDR_W-1:0] RAM_addr;
   logic              Valid_1;
   logic              busy;
   logic              entry_err;
   logic              key_drop;

   // Sequencer side
   modport master (
      input  key_code, key_stb,
      output Code_1, write_en, RAM_addr, Valid_1, busy, entry_err, key_drop
   );

   // Keypad / decider side
   modport slave (
      output key_code, key_stb,
      input  Code_1, write_en, RAM_addr, Valid_1, busy, entry_err, key_drop
   );
endinterface

// File: rtl/key_entry_sequencer_entry_timer.sv
// Inter-key idle timer: counts while enabled, clears on request, flags the last count.
module entry_timer #(
   parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic expire_c
);
   localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   logic [TMO_W-1:0] tmr_q;
   logic [TMO_W-1:0] tmr_d;

   // Next count: clear wins over counting
   always_comb begin
      tmr_d = tmr_q;
      if (clr) begin
         tmr_d = '0;
      end else if (en) begin
         tmr_d = tmr_q + TMO_W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_q <= '0;
      end else begin
         tmr_q <= tmr_d;
      end
   end

   assign expire_c = en && !clr && (tmr_q == TMO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/key_entry_sequencer.sv
// Keypad entry sequencer: writes digits to decider RAM addresses 1..DIGITS,
// the terminator to address 0, then pulses Valid_1; malformed entries are
// scrubbed to zero. Optional inter-key timeout under `ENTRY_TIMEOUT_EN.
module key_entry_sequencer
   import lock_pkg::*;
#(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned ADDR_W      = 4,
   parameter logic [3:0]  P_KEY_HASH  = KEY_HASH,
   parameter logic [3:0]  P_KEY_STAR  = KEY_STAR,
   parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
   input logic                   clk,
   input logic                   reset_n,
   key_entry_sequencer_if.master bus
);
   localparam int unsigned CNT_W = $clog2(DIGITS + 1);

   if (DIGITS < 1 || DIGITS > 14 || DIGITS >= (1 << ADDR_W) || TIMEOUT_CYC < 2) begin : g_param_chk
      $error("key_entry_sequencer: illegal DIGITS/ADDR_W/TIMEOUT_CYC");
   end

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        code_q, code_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              drop_q, drop_d;
   logic              go_flush_c;
   logic              tmr_clr_c;
   logic              tmr_expire_c;

`ifdef ENTRY_TIMEOUT_EN
   // Idle timer runs only while a partial code is held
   entry_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_entry_timer (
      .clk      (clk),
      .rst_n    (reset_n),
      .en       (state_q == ST_DIGIT),
      .clr      (tmr_clr_c),
      .expire_c (tmr_expire_c)
   );
`else
   logic unused_tmr_clr;
   assign unused_tmr_clr = tmr_clr_c;
   assign tmr_expire_c   = 1'b0;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      code_d     = code_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      drop_d     = 1'b0;
      go_flush_c = 1'b0;
      tmr_clr_c  = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DIGIT: begin
            if (bus.key_stb) begin
               tmr_clr_c = 1'b1;
               if (is_digit(bus.key_code)) begin
                  if (cnt_q < CNT_W'(DIGITS)) begin
                     we_d    = 1'b1;
                     code_d  = bus.key_code;
                     addr_d  = ADDR_W'(cnt_q) + ADDR_W'(1);
                     cnt_d   = cnt_q + CNT_W'(1);
                     state_d = ST_DIGIT;
                  end else begin
                     go_flush_c = 1'b1;
                  end
               end else if ((bus.key_code == P_KEY_HASH &&
                             (cnt_q == CNT_W'(DIGITS) || cnt_q == '0)) ||
                            (bus.key_code == P_KEY_STAR && cnt_q == CNT_W'(DIGITS))) begin
                  we_d    = 1'b1;
                  code_d  = bus.key_code;
                  addr_d  = '0;
                  state_d = ST_TERM;
               end else begin
                  go_flush_c = 1'b1;
               end
            end else if (tmr_expire_c) begin
               go_flush_c = 1'b1;
            end
         end
         ST_TERM: begin
            drop_d  = bus.key_stb;
            valid_d = 1'b1;
            state_d = ST_VALID;
         end
         ST_VALID: begin
            drop_d  = bus.key_stb;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         ST_FLUSH: begin
            drop_d = bus.key_stb;
            if (addr_q < ADDR_W'(DIGITS)) begin
               we_d   = 1'b1;
               code_d = '0;
               addr_d = addr_q + ADDR_W'(1);
            end else begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Scrub starts with address 0 on the cycle entry_err is raised
      if (go_flush_c) begin
         state_d = ST_FLUSH;
         err_d   = 1'b1;
         we_d    = 1'b1;
         code_d  = '0;
         addr_d  = '0;
         cnt_d   = '0;
      end

      busy_d = (state_d == ST_TERM) || (state_d == ST_VALID) || (state_d == ST_FLUSH);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         code_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         drop_q  <= drop_d;
      end
   end

   assign bus.Code_1    = code_q;
   assign bus.write_en  = we_q;
   assign bus.RAM_addr  = addr_q;
   assign bus.Valid_1   = valid_q;
   assign bus.busy      = busy_q;
   assign bus.entry_err = err_q;
   assign bus.key_drop  = drop_q;

endmodule
